msg_link_arbiter: RTL and testbench
===================================

// Module: msg_link_arbiter
// PURPOSE
//   Shares one message link between machine A and machine B (requesters A/B).
//   Grants ownership round-robin and forwards the owner's beats onto the link.
//   Bounds each grant by end-of-message, burst length or receiver timeout.
//   Sits between the machines and the shared link; the receiver acks beats.
// PARAMETERS
//   DATA_W     8   width of a message beat
//   MAX_BURST  4   max beats accepted per grant (>=1)
//   TURN_CYC   1   dead cycles between ownership changes (0 = none)
//   TIMEOUT    15  consecutive un-acked valid cycles before abort (>=1)
// PORTS
//   clock        in   1       rising-edge clock
//   reset_n      in   1       asynchronous reset, active low
//   req_a        in   1       A has a beat to send
//   data_a       in   DATA_W  A beat data, held stable while valid and not acked
//   last_a       in   1       A beat is final of message
//   gnt_a        out  1       A owns link (registered)
//   req_b/data_b/last_b/gnt_b  same as A, for B
//   link_valid   out  1       beat on link = gnt_x & req_x of owner
//   link_data    out  DATA_W  owner's data_x (0 when no owner)
//   link_src     out  1       0 = A, 1 = B; holds last owner when idle
//   link_ack     in   1       receiver accepts beat this cycle
//   timeout_err  out  1       one-cycle pulse: grant aborted by timeout
// BEHAVIOUR
//   Reset (async, reset_n=0): state IDLE, gnt_a=gnt_b=0, link_valid=0,
//     link_data=0, link_src=0, timeout_err=0, beat/timeout/turn counters 0,
//     priority pointer = A. In-flight beat discarded, no ack owed.
//   States: IDLE, OWN_A, OWN_B, TURN.
//   IDLE: only req_a -> OWN_A; only req_b -> OWN_B; both -> pointer side;
//     none -> stay. gnt_x asserts the cycle after req_x is sampled.
//   OWN_x: beat accepted when link_valid & link_ack; beat counter +1.
//   Release (-> TURN, or IDLE if TURN_CYC=0) on the first edge where:
//     accepted beat has last_x=1; or beat counter reaches MAX_BURST;
//     or req_x=0 (no beat pending); or timeout counter reaches TIMEOUT.
//   Timeout counter: +1 each link_valid & !link_ack cycle, clears on ack or
//     on leaving OWN_x. At TIMEOUT: timeout_err=1 for one cycle, beat dropped.
//   Ack and timeout in the same cycle: ack wins, no error.
//   last_x and MAX_BURST in the same beat: single release, no extra beat.
//   On release: gnt_x drops next cycle; pointer flips to the other side.
//   TURN: both grants 0 for exactly TURN_CYC cycles, then IDLE.
//   Grant latency after release (other side requesting): TURN_CYC+2 cycles.
//   Beat counter width $clog2(MAX_BURST+1); timeout counter $clog2(TIMEOUT+1).
//   link_ack with link_valid=0 is ignored.
//   gnt_a and gnt_b are never 1 in the same cycle.
// TESTING
//   req_a=1, 3 beats acked each cycle, last on beat 3 -> gnt_a 1 cycle after
//     req, 3 beats on link with link_src=0, gnt_a low after beat 3, 1 TURN cycle.
//   req_a and req_b both 1 from reset, long messages, MAX_BURST=4 -> A gets
//     4 beats, TURN, B gets 4 beats, TURN, A again (strict alternation).
//   req_b=1, link_ack held 0 -> timeout_err pulses on the 15th un-acked
//     cycle, gnt_b drops, pointer moves to A.
//   Ack arrives on the exact TIMEOUT cycle -> beat accepted, timeout_err
//     stays 0, grant continues.
//   reset_n pulled low mid-burst on beat 2 (async, between edges) -> all
//     outputs reset immediately; after release, req_b only -> B granted first.
//   TURN_CYC=0, A then B back-to-back -> gnt_b rises 2 cycles after A's last
//     beat; gnt_a and gnt_b never overlap.

Source files
------------

// File: rtl/msg_link_arbiter_if.sv
// msg_link_arbiter_if: requester beats, grants and the shared link.
// master = machines/receiver side, slave = arbiter side.
interface msg_link_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req_a;
    logic [DATA_W-1:0] data_a;
    logic              last_a;
    logic              gnt_a;
    logic              req_b;
    logic [DATA_W-1:0] data_b;
    logic              last_b;
    logic              gnt_b;
    logic              link_valid;
    logic [DATA_W-1:0] link_data;
    logic              link_src;
    logic              link_ack;
    logic              timeout_err;

    modport master (
        output req_a, data_a, last_a,
        output req_b, data_b, last_b,
        output link_ack,
        input  gnt_a, gnt_b,
        input  link_valid, link_data, link_src,
        input  timeout_err
    );

    modport slave (
        input  req_a, data_a, last_a,
        input  req_b, data_b, last_b,
        input  link_ack,
        output gnt_a, gnt_b,
        output link_valid, link_data, link_src,
        output timeout_err
    );
endinterface

// File: rtl/msg_link_arbiter.sv
// msg_link_arbiter: round-robin owner of one message link for A/B.
// A grant ends on last beat, burst limit, idle owner or ack timeout.
module msg_link_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int TURN_CYC  = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic clock,
    input  logic reset_n,
    msg_link_arbiter_if.slave bus
);
    localparam int BW  = $clog2(MAX_BURST + 1);
    localparam int TOW = $clog2(TIMEOUT + 1);
    localparam int TW  = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;

    localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [TOW-1:0] TO_LAST    = TOW'(TIMEOUT - 1);
    localparam logic [TW-1:0]  TURN_LAST  =
        TW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B,
        TURN
    } state_t;

    state_t         state_q, state_d;
    logic           ptr_q, ptr_d;
    logic           src_q, src_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [TOW-1:0] to_q, to_d;
    logic [TW-1:0]  turn_q, turn_d;

    logic              own_a;
    logic              own_b;
    logic              own_req;
    logic              own_last;
    logic [DATA_W-1:0] own_data;
    logic              beat_acc;
    logic              to_hit;
    logic              burst_hit;
    logic              rel_now;

    // Owner view of the link and the reasons a grant must end now.
    always_comb begin
        own_a    = (state_q == OWN_A);
        own_b    = (state_q == OWN_B);
        own_req  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        if (own_a) begin
            own_req  = bus.req_a;
            own_last = bus.last_a;
            own_data = bus.data_a;
        end else if (own_b) begin
            own_req  = bus.req_b;
            own_last = bus.last_b;
            own_data = bus.data_b;
        end
        beat_acc  = own_req & bus.link_ack;
        // An ack in the final waiting cycle still lands the beat.
        to_hit    = own_req & ~bus.link_ack & (to_q == TO_LAST);
        burst_hit = beat_acc & (beat_q == BURST_LAST);
        rel_now   = (own_a | own_b) &
                    (~own_req | to_hit | burst_hit |
                     (beat_acc & own_last));
    end

    assign bus.gnt_a       = own_a;
    assign bus.gnt_b       = own_b;
    assign bus.link_valid  = own_req;
    assign bus.link_data   = own_data;
    assign bus.link_src    = src_q;
    assign bus.timeout_err = to_hit;

    // Arbitration, grant release, turnaround and counters.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        beat_d  = beat_q;
        to_d    = to_q;
        turn_d  = turn_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_a & (~bus.req_b | ~ptr_q)) begin
                    state_d = OWN_A;
                    src_d   = 1'b0;
                end else if (bus.req_b) begin
                    state_d = OWN_B;
                    src_d   = 1'b1;
                end
            end
            OWN_A, OWN_B: begin
                if (rel_now) begin
                    state_d = (TURN_CYC == 0) ? IDLE : TURN;
                    ptr_d   = own_a;
                    beat_d  = '0;
                    to_d    = '0;
                    turn_d  = '0;
                end else if (beat_acc) begin
                    beat_d = beat_q + BW'(1);
                    to_d   = '0;
                end else if (own_req) begin
                    to_d = to_q + TOW'(1);
                end
            end
            TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = IDLE;
                    turn_d  = '0;
                end else begin
                    turn_d = turn_q + TW'(1);
                end
            end
        endcase
    end

    // State and counter registers; reset hands priority to A.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            src_q   <= 1'b0;
            beat_q  <= '0;
            to_q    <= '0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            beat_q  <= beat_d;
            to_q    <= to_d;
            turn_q  <= turn_d;
        end
    end
endmodule

// File: tb/tb_msg_link_arbiter.sv
// tb_msg_link_arbiter: random producers against a transaction model.
// Two DUTs: TURN_CYC=1 (ch0) and TURN_CYC=0 (ch1).
module tb_msg_link_arbiter;
    localparam int MAXB = 4;
    localparam int TMO  = 15;

    typedef struct packed {
        logic       ga;
        logic       gb;
        logic       v;
        logic [7:0] d;
        logic       s;
        logic       te;
    } out_t;

    typedef struct packed {
        logic       s;
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    msg_link_arbiter_if #(.DATA_W(8)) if0 ();
    msg_link_arbiter_if #(.DATA_W(8)) if1 ();

    msg_link_arbiter #(
        .DATA_W(8), .MAX_BURST(MAXB), .TURN_CYC(1), .TIMEOUT(TMO)
    ) u0 (
        .clock(clk), .reset_n(rst_n), .bus(if0.slave)
    );

    msg_link_arbiter #(
        .DATA_W(8), .MAX_BURST(MAXB), .TURN_CYC(0), .TIMEOUT(TMO)
    ) u1 (
        .clock(clk), .reset_n(rst_n), .bus(if1.slave)
    );

    out_t act0, act1;
    assign act0 = {if0.gnt_a, if0.gnt_b, if0.link_valid,
                   if0.link_data, if0.link_src, if0.timeout_err};
    assign act1 = {if1.gnt_a, if1.gnt_b, if1.link_valid,
                   if1.link_data, if1.link_src, if1.timeout_err};

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    out_t  eq0[$], eq1[$];
    beat_t bq0[$], bq1[$];
    logic  tq0[$], tq1[$];

    // Reference: owner -1 none / 0 A / 1 B, cool = dead cycles left.
    int         owner[2], cool[2], beats[2], waited[2];
    int         prio[2], src[2];
    bit         pend[2][2], plast[2][2];
    logic [7:0] pdata[2][2];
    int         rem[2][2];
    bit         ack[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k]  = -1;
            cool[k]   = 0;
            beats[k]  = 0;
            waited[k] = 0;
            prio[k]   = 0;
            src[k]    = 0;
            ack[k]    = 1'b0;
            for (int x = 0; x < 2; x++) begin
                pend[k][x]  = 1'b0;
                plast[k][x] = 1'b0;
                pdata[k][x] = 8'h00;
                rem[k][x]   = 0;
            end
        end
    endtask

    task automatic apply();
        if0.req_a    = pend[0][0];
        if0.data_a   = pdata[0][0];
        if0.last_a   = plast[0][0];
        if0.req_b    = pend[0][1];
        if0.data_b   = pdata[0][1];
        if0.last_b   = plast[0][1];
        if0.link_ack = ack[0];
        if1.req_a    = pend[1][0];
        if1.data_a   = pdata[1][0];
        if1.last_a   = plast[1][0];
        if1.req_b    = pend[1][1];
        if1.data_b   = pdata[1][1];
        if1.last_b   = plast[1][1];
        if1.link_ack = ack[1];
    endtask

    function automatic int reqp(input int ph);
        case (ph)
            1:       return 100;
            2:       return 50;
            default: return 60;
        endcase
    endfunction

    // Producers offer a beat and hold it until accepted or dropped.
    task automatic produce(input int k, input int ph);
        for (int x = 0; x < 2; x++) begin
            if (!pend[k][x] && !(ph == 5 && x == 0) &&
                $urandom_range(0, 99) < reqp(ph)) begin
                if (rem[k][x] == 0)
                    rem[k][x] = (ph == 1) ? $urandom_range(8, 12)
                                          : $urandom_range(1, 6);
                pend[k][x]  = 1'b1;
                pdata[k][x] = 8'($urandom);
                plast[k][x] = (rem[k][x] == 1);
            end
        end
        case (ph)
            0:       ack[k] = ($urandom_range(0, 99) < 75);
            1, 5:    ack[k] = 1'b1;
            2:       ack[k] = 1'b0;
            3:       ack[k] = (owner[k] >= 0) && (waited[k] == TMO - 1);
            default: ack[k] = ($urandom_range(0, 99) < 12);
        endcase
    endtask

    task automatic model_step(input int k, input int tc);
        int   o, w;
        bit   v, a, te, acc, rel;
        out_t e;
        o = owner[k];
        a = ack[k];
        v = 1'b0;
        e.d = 8'h00;
        if (o >= 0) begin
            v   = pend[k][o];
            e.d = pdata[k][o];
        end
        te   = v && !a && (waited[k] == TMO - 1);
        e.ga = (o == 0);
        e.gb = (o == 1);
        e.v  = v;
        e.s  = (src[k] == 1);
        e.te = te;
        if (k == 0) eq0.push_back(e);
        else        eq1.push_back(e);
        if (o >= 0) begin
            acc = v && a;
            rel = !pend[k][o] || te ||
                  (acc && (plast[k][o] || beats[k] + 1 == MAXB));
            if (acc) begin
                if (k == 0) bq0.push_back({o == 1, pdata[k][o], plast[k][o]});
                else        bq1.push_back({o == 1, pdata[k][o], plast[k][o]});
            end
            if (te) begin
                if (k == 0) tq0.push_back(o == 1);
                else        tq1.push_back(o == 1);
            end
            if (acc || te) begin
                pend[k][o] = 1'b0;
                rem[k][o]  = rem[k][o] - 1;
            end
            if (rel) begin
                prio[k]   = 1 - o;
                owner[k]  = -1;
                cool[k]   = tc;
                beats[k]  = 0;
                waited[k] = 0;
            end else if (acc) begin
                beats[k]++;
                waited[k] = 0;
            end else if (v) begin
                waited[k]++;
            end
        end else if (cool[k] > 0) begin
            cool[k]--;
        end else begin
            if (pend[k][0] && pend[k][1]) w = prio[k];
            else if (pend[k][0])          w = 0;
            else if (pend[k][1])          w = 1;
            else                          w = -1;
            owner[k] = w;
            if (w >= 0) src[k] = w;
        end
    endtask

    task automatic step(input int ph);
        @(posedge clk);
        #1;
        produce(0, ph);
        produce(1, ph);
        apply();
        model_step(0, 1);
        model_step(1, 0);
    endtask

    task automatic run(input int ph, input int n);
        for (int i = 0; i < n; i++) step(ph);
    endtask

    task automatic check_chan(input int k, input out_t a, input logic ak);
        out_t  e;
        beat_t eb, ab;
        logic  es;
        bit    none;
        none = 1'b1;
        e    = '0;
        if (k == 0 && eq0.size() > 0) begin
            e = eq0.pop_front(); none = 1'b0;
        end else if (k == 1 && eq1.size() > 0) begin
            e = eq1.pop_front(); none = 1'b0;
        end
        checks++;
        if (none || a !== e) begin
            failures++;
            $display("FAIL out%0d t=%0t got=%h exp=%h noexp=%0d",
                     k, $time, a, e, none);
        end
        checks++;
        if (a.ga && a.gb) begin
            failures++;
            $display("FAIL excl%0d t=%0t gnt_a=1 gnt_b=1 exp not both",
                     k, $time);
        end
        if (a.v && ak) begin
            ab   = {a.s, a.d, (a.s ? (k == 0 ? if0.last_b : if1.last_b)
                                   : (k == 0 ? if0.last_a : if1.last_a))};
            none = 1'b1;
            eb   = '0;
            if (k == 0 && bq0.size() > 0) begin
                eb = bq0.pop_front(); none = 1'b0;
            end else if (k == 1 && bq1.size() > 0) begin
                eb = bq1.pop_front(); none = 1'b0;
            end
            checks++;
            if (none || ab !== eb) begin
                failures++;
                $display("FAIL beat%0d t=%0t got=%h exp=%h noexp=%0d",
                         k, $time, ab, eb, none);
            end
        end
        if (a.te) begin
            none = 1'b1;
            es   = 1'b0;
            if (k == 0 && tq0.size() > 0) begin
                es = tq0.pop_front(); none = 1'b0;
            end else if (k == 1 && tq1.size() > 0) begin
                es = tq1.pop_front(); none = 1'b0;
            end
            checks++;
            if (none || a.s !== es) begin
                failures++;
                $display("FAIL tmo%0d t=%0t src=%0d exp=%0d noexp=%0d",
                         k, $time, a.s, es, none);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_chan(0, act0, if0.link_ack);
            check_chan(1, act1, if1.link_ack);
        end
    end

    task automatic reset_check(input string tag);
        checks++;
        if (act0 !== '0) begin
            failures++;
            $display("FAIL %s0 got=%h exp=0", tag, act0);
        end
        checks++;
        if (act1 !== '0) begin
            failures++;
            $display("FAIL %s1 got=%h exp=0", tag, act1);
        end
    endtask

    initial begin
        bit found;
        model_reset();
        apply();
        #1 rst_n = 1'b0;
        #1 reset_check("rst");
        #10 rst_n = 1'b1;
        mon_en = 1'b1;
        run(0, 400);
        run(1, 200);
        run(2, 200);
        run(3, 200);
        run(4, 300);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(0);
            found = (owner[0] >= 0) && (beats[0] == 1) &&
                    pend[0][owner[0]];
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL burst_wait got=timeout exp=beat2 on ch0");
        end
        step(0);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1 reset_check("async_rst");
        eq0.delete(); eq1.delete();
        bq0.delete(); bq1.delete();
        tq0.delete(); tq1.delete();
        model_reset();
        apply();
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        run(5, 60);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        checks++;
        if (eq0.size() + eq1.size() + bq0.size() + bq1.size() +
            tq0.size() + tq1.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0 pending expectations",
                     eq0.size() + eq1.size() + bq0.size() + bq1.size() +
                     tq0.size() + tq1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
